// File: rtl/cache_level_1.sv
// cache_level_1: direct-mapped, write-through / no-allocate L1 data cache.
// Each line holds four 32-bit words. A read miss stalls the CPU and fetches
// the whole line from L2. The load is then replayed and hits.
// Stores go straight through to L2 in the same cycle. A store that hits
// also updates the cached word.
// Optional feature: define CACHE_LEVEL_1_STATS_EN to add the hit_count and
// miss_count outputs with their counters.
module cache_level_1 #(
  parameter int LINES = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         read_index,
  input  logic         write_index,
  input  logic [31:0]  addr,
  input  logic [31:0]  write_data,
  output logic [31:0]  read_data,
  output logic         stall,
  output logic         l2_read_index,
  output logic         l2_write_index,
  output logic [31:0]  l2_addr,
  output logic [31:0]  l2_write_data,
  input  logic         l2_stall,
  input  logic [127:0] l2_block
`ifdef CACHE_LEVEL_1_STATS_EN
  ,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
`endif
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic {IDLE, FILL} state_t;

  state_t            state;

  logic [1:0]        offset;
  logic [IDX_W-1:0]  index;
  logic [TAG_W-1:0]  tag;

  logic [31:0]       word_mem [LINES][4];
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [LINES-1:0]  valid;

  logic              hit;
  logic              is_idle;
  logic              wr_req;
  logic              rd_req;
  logic              rd_hit;
  logic              rd_miss;
  logic              filling;
  logic              fill_done;

  assign offset = addr[1:0];
  assign index  = addr[IDX_W+1:2];
  assign tag    = addr[31:IDX_W+2];

  assign hit     = valid[index] & (tag_mem[index] == tag);
  assign is_idle = (state == IDLE);

  // All requests are masked while rst is low, so the CPU and L2 sides see a
  // quiet cache during reset. A simultaneous read and write counts as a
  // write only.
  assign wr_req    = rst & is_idle & write_index;
  assign rd_req    = rst & is_idle & read_index & ~write_index;
  assign rd_hit    = rd_req & hit;
  assign rd_miss   = rd_req & ~hit;
  assign filling   = rst & (state == FILL);
  assign fill_done = filling & ~l2_stall;

  // CPU-facing and L2-facing outputs, decoded combinationally from the request
  always_comb begin
    stall          = rd_miss | filling;
    read_data      = '0;
    l2_read_index  = filling;
    l2_write_index = wr_req;
    l2_addr        = '0;
    l2_write_data  = '0;
    if (rd_hit) begin
      read_data = word_mem[index][offset];
    end
    if (filling) begin
      l2_addr = {addr[31:2], 2'b00};
    end else if (wr_req) begin
      l2_addr       = addr;
      l2_write_data = write_data;
    end
  end

  // Control state: FSM and valid bits. Reset abandons any fill in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      valid <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_miss) begin
            state <= FILL;
          end
        end
        FILL: begin
          if (!l2_stall) begin
            valid[index] <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag and data storage. A line fill writes all four words. A write hit
  // patches one word. Neither array is reset.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      tag_mem[index] <= tag;
      for (int w = 0; w < 4; w++) begin
        word_mem[index][w] <= l2_block[w*32 +: 32];
      end
    end else if (wr_req && hit) begin
      word_mem[index][offset] <= write_data;
    end
  end

`ifdef CACHE_LEVEL_1_STATS_EN
  // Hit/miss statistics. A miss is counted on entry to FILL. Both counters wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (rd_hit) begin
        hit_count <= hit_count + 32'd1;
      end
      if (rd_miss) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_level_1.sv
// Directed bench for cache_level_1 (LINES = 8): cold fill, rereads, write
// hit/miss, set conflict, reset during a fill, and read dropped mid-fill.
module tb_cache_level_1;

  logic         clk;
  logic         rst;
  logic         read_index;
  logic         write_index;
  logic [31:0]  addr;
  logic [31:0]  write_data;
  logic [31:0]  read_data;
  logic         stall;
  logic         l2_read_index;
  logic         l2_write_index;
  logic [31:0]  l2_addr;
  logic [31:0]  l2_write_data;
  logic         l2_stall;
  logic [127:0] l2_block;
`ifdef CACHE_LEVEL_1_STATS_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  localparam logic [127:0] BLK_A = {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
  localparam logic [127:0] BLK_E = {32'h6000_0003, 32'h6000_0002, 32'h6000_0001, 32'h6000_0000};
  localparam logic [127:0] BLK_F = {32'h8000_0003, 32'h8000_0002, 32'h8000_0001, 32'h8000_0000};

  cache_level_1 #(.LINES(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .read_index     (read_index),
    .write_index    (write_index),
    .addr           (addr),
    .write_data     (write_data),
    .read_data      (read_data),
    .stall          (stall),
    .l2_read_index  (l2_read_index),
    .l2_write_index (l2_write_index),
    .l2_addr        (l2_addr),
    .l2_write_data  (l2_write_data),
    .l2_stall       (l2_stall),
    .l2_block       (l2_block)
`ifdef CACHE_LEVEL_1_STATS_EN
    ,
    .hit_count      (hit_count),
    .miss_count     (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    read_index  = rd;
    write_index = wr;
    addr        = a;
    write_data  = d;
  endtask

  // Issue a load and hold it until stall drops (bounded). L2 is busy for the
  // first l2_wait cycles of FILL. Returns the number of stalled cycles and
  // the L2 request seen in the first FILL cycle. Returns mid-cycle with the
  // load hitting.
  task automatic read_miss(input logic [31:0] a, input logic [127:0] blk, input int l2_wait,
                           output int cycles, output logic fill_req, output logic [31:0] fill_addr);
    drive(1'b1, 1'b0, a, 32'h0);
    l2_block  = blk;
    cycles    = 0;
    fill_req  = 1'b0;
    fill_addr = 32'h0;
    for (int c = 0; c < 20; c++) begin
      l2_stall = (c >= 1 && c <= l2_wait);
      #2;
      if (c == 1) begin
        fill_req  = l2_read_index;
        fill_addr = l2_addr;
      end
      if (!stall) break;
      cycles++;
      step();
    end
    l2_stall = 1'b0;
  endtask

  int          n;
  logic        fr;
  logic [31:0] fa;

  initial begin
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    l2_stall = 1'b0;
    l2_block = '0;

    // Reset: outputs quiet even with requests presented
    step();
    drive(1'b1, 1'b0, 32'h40, 32'h0);
    #2;
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_l2_rd", {31'b0, l2_read_index}, 32'd0);
    chk("rst_l2_addr", l2_addr, 32'h0);
    chk("rst_rdata", read_data, 32'h0);
    drive(1'b0, 1'b1, 32'h44, 32'h99);
    #1;
    chk("rst_l2_wr", {31'b0, l2_write_index}, 32'd0);
    chk("rst_l2_addr_wr", l2_addr, 32'h0);
    step();
    rst = 1'b1;

    // Idle: no request, everything zero
    drive(1'b0, 1'b0, 32'h40, 32'h77);
    #2;
    chk("idle_stall", {31'b0, stall}, 32'd0);
    chk("idle_l2_wr", {31'b0, l2_write_index}, 32'd0);
    chk("idle_l2_addr", l2_addr, 32'h0);
    chk("idle_l2_wdata", l2_write_data, 32'h0);
    chk("idle_rdata", read_data, 32'h0);
    step();

    // Cold read of 0x40, L2 busy 3 cycles: 5 stall cycles, then A
    read_miss(32'h40, BLK_A, 3, n, fr, fa);
    chk("cold_stall_cycles", n, 32'd5);
    chk("cold_l2_rd", {31'b0, fr}, 32'd1);
    chk("cold_l2_addr", fa, 32'h40);
    chk("cold_rdata", read_data, 32'hAAAA_0001);
    step();

    // Rereads on consecutive cycles with no stall
    drive(1'b1, 1'b0, 32'h41, 32'h0); #2;
    chk("rr41_stall", {31'b0, stall}, 32'd0);
    chk("rr41_rdata", read_data, 32'hBBBB_0002);
    step();
    drive(1'b1, 1'b0, 32'h42, 32'h0); #2;
    chk("rr42_stall", {31'b0, stall}, 32'd0);
    chk("rr42_rdata", read_data, 32'hCCCC_0003);
    step();
    drive(1'b1, 1'b0, 32'h43, 32'h0); #2;
    chk("rr43_stall", {31'b0, stall}, 32'd0);
    chk("rr43_rdata", read_data, 32'hDDDD_0004);
    step();

    // Write hit to 0x42, write-through in the same cycle
    drive(1'b0, 1'b1, 32'h42, 32'h1234); #2;
    chk("wh_stall", {31'b0, stall}, 32'd0);
    chk("wh_l2_wr", {31'b0, l2_write_index}, 32'd1);
    chk("wh_l2_addr", l2_addr, 32'h42);
    chk("wh_l2_wdata", l2_write_data, 32'h1234);
    chk("wh_l2_rd", {31'b0, l2_read_index}, 32'd0);
    step();
    drive(1'b1, 1'b0, 32'h42, 32'h0); #2;
    chk("wh_read_stall", {31'b0, stall}, 32'd0);
    chk("wh_read_rdata", read_data, 32'h1234);
    step();
    drive(1'b1, 1'b0, 32'h43, 32'h0); #2;
    chk("wh_neighbour", read_data, 32'hDDDD_0004);
    step();

    // Conflict: 0x61 shares index 0 with 0x40 -> miss and refill, aligned L2 address
    read_miss(32'h61, BLK_E, 0, n, fr, fa);
    chk("conf_stall_cycles", n, 32'd2);
    chk("conf_l2_addr", fa, 32'h60);
    chk("conf_rdata", read_data, 32'h6000_0001);
    step();
    drive(1'b1, 1'b0, 32'h40, 32'h0); #2;
    chk("conf_evicted_stall", {31'b0, stall}, 32'd1);
    chk("conf_evicted_rdata", read_data, 32'h0);
    step();
    read_miss(32'h40, BLK_A, 0, n, fr, fa);
    chk("conf_refill_cycles", n, 32'd1);
    chk("conf_refill_rdata", read_data, 32'hAAAA_0001);
    step();

    // Write miss to 0x80: no stall, no fill, array untouched
    drive(1'b0, 1'b1, 32'h80, 32'h5555); #2;
    chk("wm_stall", {31'b0, stall}, 32'd0);
    chk("wm_l2_wr", {31'b0, l2_write_index}, 32'd1);
    chk("wm_l2_rd", {31'b0, l2_read_index}, 32'd0);
    chk("wm_l2_addr", l2_addr, 32'h80);
    step();
    drive(1'b1, 1'b0, 32'h40, 32'h0); #2;
    chk("wm_line_kept_stall", {31'b0, stall}, 32'd0);
    chk("wm_line_kept_rdata", read_data, 32'hAAAA_0001);
    step();
    // Read 0x80 misses, then reset in the middle of the fill
    l2_stall = 1'b1;
    drive(1'b1, 1'b0, 32'h80, 32'h0); #2;
    chk("wm_read_miss", {31'b0, stall}, 32'd1);
    step();
    #2;
    chk("mid_fill_stall", {31'b0, stall}, 32'd1);
    chk("mid_fill_l2_rd", {31'b0, l2_read_index}, 32'd1);
    chk("mid_fill_l2_addr", l2_addr, 32'h80);
    rst = 1'b0;
    #1;
    chk("mid_rst_stall", {31'b0, stall}, 32'd0);
    chk("mid_rst_l2_rd", {31'b0, l2_read_index}, 32'd0);
    chk("mid_rst_l2_addr", l2_addr, 32'h0);
    step();
    rst = 1'b1;
    l2_stall = 1'b0;

    // Load dropped while in FILL: fill still completes
    drive(1'b1, 1'b0, 32'h40, 32'h0);
    l2_block = BLK_A;
    l2_stall = 1'b1;
    #2;
    chk("drop_miss_after_rst", {31'b0, stall}, 32'd1);
    step();
    read_index = 1'b0;
    #2;
    chk("drop_fill_stall", {31'b0, stall}, 32'd1);
    chk("drop_fill_l2_rd", {31'b0, l2_read_index}, 32'd1);
    chk("drop_fill_rdata", read_data, 32'h0);
    step();
    l2_stall = 1'b0;
    #2;
    chk("drop_fill_last", {31'b0, stall}, 32'd1);
    step();
    drive(1'b1, 1'b0, 32'h43, 32'h0); #2;
    chk("drop_after_stall", {31'b0, stall}, 32'd0);
    chk("drop_after_rdata", read_data, 32'hDDDD_0004);
    step();

    // Address whose fill was abandoned by reset still misses
    read_miss(32'h82, BLK_F, 0, n, fr, fa);
    chk("abandon_stall_cycles", n, 32'd2);
    chk("abandon_l2_addr", fa, 32'h80);
    chk("abandon_rdata", read_data, 32'h8000_0002);
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/cache_level_1.md
CACHE_LEVEL_1 -- requirements
Module: cache_level_1

Interface
REQ-001 SHALL have parameter LINES, default 8, meaning number of direct-mapped lines (power of two, 4 words per line).
REQ-002 SHALL have port clk  input  1  system clock, rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port read_index  input  1  CPU load request.
REQ-005 SHALL have port write_index  input  1  CPU store request.
REQ-006 SHALL have port addr  input  32  CPU word address.
REQ-007 SHALL have port write_data  input  32  CPU store data.
REQ-008 SHALL have port read_data  output  32  load data, valid when read_index=1 and stall=0.
REQ-009 SHALL have port stall  output  1  CPU hold request.
REQ-010 SHALL have port l2_read_index  output  1  line fetch request to L2.
REQ-011 SHALL have port l2_write_index  output  1  write-through request to L2.
REQ-012 SHALL have port l2_addr  output  32  address to L2.
REQ-013 SHALL have port l2_write_data  output  32  store data to L2.
REQ-014 SHALL have port l2_stall  input  1  L2 busy; returned block is invalid while high.
REQ-015 SHALL have port l2_block  input  128  4-word block from L2, word 0 in bits [31:0].

Function
REQ-016 SHALL decode offset=addr[1:0], index=addr[log2(LINES)+1:2], and tag=remaining upper bits.
REQ-017 SHALL define hit = valid[index] & (tag_store[index]==tag), combinational.
REQ-018 SHALL implement FSM states IDLE and FILL, with reset state IDLE.
REQ-019 SHALL assert stall combinationally when read_index=1 and hit=0, or when state=FILL.
REQ-020 SHALL, on read hit in IDLE, drive read_data=word[offset] combinationally, with zero stall cycles.
REQ-021 SHALL, on read miss in IDLE, go to FILL at the next edge.
REQ-022 SHALL, in FILL, drive l2_read_index=1 and l2_addr={addr[31:2],2'b00}.
REQ-023 SHALL, at the first edge in FILL with l2_stall=0, write l2_block into the line, write tag_store, set valid, and return to IDLE, so the replayed load hits on the next cycle.
REQ-024 SHALL give miss latency of 2 cycles plus the number of cycles l2_stall is high.
REQ-025 SHALL handle write_index=1 in IDLE as write-through, no-allocate: l2_write_index=1, l2_addr=addr, l2_write_data=write_data in the same cycle, with stall=0.
REQ-026 SHALL, on write hit, update word[offset] at the edge and leave valid and tag unchanged; on write miss, leave the cache array unchanged.
REQ-027 SHALL treat read_index=1 with write_index=1 as a write, ignoring the read.
REQ-028 SHALL ignore write_index while in FILL, since the CPU is stalled.
REQ-029 SHALL, when read_index drops while in FILL, complete the fill and then return to IDLE.
REQ-030 SHALL drive read_data=0 when read_index=0 or on a miss.
REQ-031 SHALL drive l2_read_index, l2_write_index, l2_addr and l2_write_data to 0 when no request is active.

Reset
REQ-032 SHALL, on rst=0, asynchronously set state=IDLE and clear every valid bit.
REQ-033 SHALL, during reset, drive stall=0, l2_read_index=0, l2_write_index=0, and l2_addr=0.
REQ-034 SHALL, on reset during FILL, abandon the fill; the line SHALL remain invalid.
REQ-035 SHALL NOT require reset of tag and data storage.

Configuration
REQ-036 SHALL, with macro CACHE_LEVEL_1_STATS_EN defined, add outputs hit_count[31:0] and miss_count[31:0].
REQ-037 SHALL, with that macro defined, increment hit_count once per read hit accepted in IDLE, increment miss_count once per FILL entry, wrap both counters at 2^32, and clear both on reset.
REQ-038 SHALL, without the macro, omit both ports and both counters, leaving all other behaviour identical.

Verification
REQ-039 SHALL cover cold read: reset, read addr=0x40, l2_stall=1 for 3 cycles, l2_block={D,C,B,A} -> stall=1 for 5 cycles, then read_data=A.
REQ-040 SHALL cover reread: read 0x41, 0x42, 0x43 after the fill -> stall=0, read_data=B, C, D on consecutive cycles.
REQ-041 SHALL cover write hit: write 0x42 with 0x1234 -> l2_write_index=1, l2_addr=0x42 in the same cycle; then read 0x42 -> 0x1234 with no stall.
REQ-042 SHALL cover conflict: read 0x40, then read 0x60 with LINES=8 (same index) -> miss and refill; then read 0x40 -> miss again.
REQ-043 SHALL cover write miss: write 0x80 -> no stall, no fill; then read 0x80 -> miss.
REQ-044 SHALL cover reset mid-fill: rst=0 during FILL -> stall=0 and l2_read_index=0 immediately; then read of the same address -> miss.
